// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles the fetch (i_*), load/store (d_*) and shared
// master (m_*) Wishbone-style signals around bus_arbiter.
//   modport master : the arbiter itself (it masters the shared bus and
//                    answers the two client ports)
//   modport slave  : the surroundings (fetch stage, load/store unit and
//                    memory interconnect)
// Handshake: a client holds x_cyc_i for a whole burst and raises x_stb_i for
// each beat; a beat completes on a rising edge where the granted client's
// stb and the returned ack are both 1. A client that is not granted sees
// ack=0 and keeps its request (cyc/stb/address/data) stable until served.
interface bus_arbiter_if #(
    parameter int AW = 64
);
    // Fetch port
    logic          i_cyc_i;
    logic          i_stb_i;
    logic [AW-1:0] i_adr_i;
    logic          i_ack_o;
    logic [31:0]   i_dat_o;
    logic          i_err_o;
    // Load/store port
    logic          d_cyc_i;
    logic          d_stb_i;
    logic          d_we_i;
    logic [7:0]    d_sel_i;
    logic [AW-1:0] d_adr_i;
    logic [63:0]   d_dat_i;
    logic          d_ack_o;
    logic [63:0]   d_dat_o;
    logic          d_err_o;
    // Shared master bus
    logic          m_cyc_o;
    logic          m_stb_o;
    logic          m_we_o;
    logic [7:0]    m_sel_o;
    logic [AW-1:0] m_adr_o;
    logic [63:0]   m_dat_o;
    logic          m_ack_i;
    logic [63:0]   m_dat_i;
    // Debug view of the arbiter FSM (0 = IDLE, 1 = GNT_I, 2 = GNT_D)
    logic [1:0]    dbg_state;
    logic          dbg_last_d;

    modport master (
        input  i_cyc_i, i_stb_i, i_adr_i,
        output i_ack_o, i_dat_o, i_err_o,
        input  d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
        output d_ack_o, d_dat_o, d_err_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  m_ack_i, m_dat_i,
        output dbg_state, dbg_last_d
    );

    modport slave (
        output i_cyc_i, i_stb_i, i_adr_i,
        input  i_ack_o, i_dat_o, i_err_o,
        output d_cyc_i, d_stb_i, d_we_i, d_sel_i, d_adr_i, d_dat_i,
        input  d_ack_o, d_dat_o, d_err_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output m_ack_i, m_dat_i,
        input  dbg_state, dbg_last_d
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one 64-bit Wishbone-style master bus between the
// instruction-fetch port (I) and the load/store port (D). Round-robin between
// simultaneous requesters using last_d (last owner, 1 = D); a granted port
// keeps the bus for its whole CYC burst, and releasing costs one dead cycle.
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN -- adds an 8-bit stall
// counter that pulses x_err_o and revokes the grant after TIMEOUT stalled
// strobe cycles. Without it the err outputs are tied to 0.
module bus_arbiter #(
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_d;
    logic          w_next_last_d;
    logic          w_owner_stb;
    logic          w_timeout;
    logic [AW-1:0] w_m_adr;

    // Round-robin choice used both from IDLE and on release: a lone requester
    // wins, two requesters go to the one that did not own the bus last.
    function automatic state_t pick(input logic rq_i, input logic rq_d,
                                    input logic last_d);
        if (rq_i && rq_d) begin
            return last_d ? ST_GNT_I : ST_GNT_D;
        end else if (rq_d) begin
            return ST_GNT_D;
        end else if (rq_i) begin
            return ST_GNT_I;
        end else begin
            return ST_IDLE;
        end
    endfunction

    // A live beat of the current owner; acks are only meaningful here.
    assign w_owner_stb = ((r_state == ST_GNT_I) && bus.i_cyc_i && bus.i_stb_i) ||
                         ((r_state == ST_GNT_D) && bus.d_cyc_i && bus.d_stb_i);

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Stall counter: cleared by any ack or grant change, counts stalled beats.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt <= 8'd0;
        end else if (bus.m_ack_i || (r_state != w_next_state)) begin
            r_cnt <= 8'd0;
        end else if (w_owner_stb) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // The TIMEOUT-th consecutive stalled beat is the one that aborts.
    assign w_timeout = w_owner_stb && !bus.m_ack_i &&
                       (r_cnt == 8'(TIMEOUT - 1));
`else
    logic w_unused_timeout;

    // No watchdog: a hung slave keeps the bus.
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // State register: grant and last-owner flag, abandoned on reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= ST_IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_last_d <= w_next_last_d;
        end
    end

    // Next-state logic: hold during a burst, re-arbitrate on release, drop to
    // IDLE on timeout so the aborted owner gets a cycle to lower cyc.
    always_comb begin
        w_next_state  = r_state;
        w_next_last_d = r_last_d;
        case (r_state)
            ST_IDLE: begin
                w_next_state = pick(bus.i_cyc_i, bus.d_cyc_i, r_last_d);
            end
            ST_GNT_I: begin
                if (!bus.i_cyc_i) begin
                    w_next_last_d = 1'b0;
                    w_next_state  = pick(bus.i_cyc_i, bus.d_cyc_i, 1'b0);
                end else if (w_timeout) begin
                    w_next_last_d = 1'b0;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (!bus.d_cyc_i) begin
                    w_next_last_d = 1'b1;
                    w_next_state  = pick(bus.i_cyc_i, bus.d_cyc_i, 1'b1);
                end else if (w_timeout) begin
                    w_next_last_d = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: steer the owner onto the master bus and route the slave
    // response back to the owner only; everything is 0 while IDLE.
    always_comb begin
        bus.m_cyc_o = 1'b0;
        bus.m_stb_o = 1'b0;
        bus.m_we_o  = 1'b0;
        bus.m_sel_o = 8'h00;
        bus.m_dat_o = 64'd0;
        w_m_adr     = '0;
        bus.i_ack_o = 1'b0;
        bus.i_dat_o = 32'd0;
        bus.i_err_o = 1'b0;
        bus.d_ack_o = 1'b0;
        bus.d_dat_o = 64'd0;
        bus.d_err_o = 1'b0;
        case (r_state)
            ST_GNT_I: begin
                // Fetch is read-only and 32 bits wide; bit 2 picks the half.
                bus.m_cyc_o = bus.i_cyc_i;
                bus.m_stb_o = bus.i_stb_i;
                bus.m_sel_o = bus.i_adr_i[2] ? 8'hF0 : 8'h0F;
                w_m_adr     = bus.i_adr_i;
                bus.i_ack_o = bus.m_ack_i && w_owner_stb;
                bus.i_dat_o = bus.i_adr_i[2] ? bus.m_dat_i[63:32] : bus.m_dat_i[31:0];
                bus.i_err_o = w_timeout;
            end
            ST_GNT_D: begin
                bus.m_cyc_o = bus.d_cyc_i;
                bus.m_stb_o = bus.d_stb_i;
                bus.m_we_o  = bus.d_we_i;
                bus.m_sel_o = bus.d_sel_i;
                bus.m_dat_o = bus.d_dat_i;
                w_m_adr     = bus.d_adr_i;
                bus.d_ack_o = bus.m_ack_i && w_owner_stb;
                bus.d_dat_o = bus.m_dat_i;
                bus.d_err_o = w_timeout;
            end
            default: begin
            end
        endcase
    end

    assign bus.m_adr_o    = w_m_adr;
    assign bus.dbg_state  = r_state;
    assign bus.dbg_last_d = r_last_d;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter. Inputs change 1 time unit
// after a rising edge; outputs are checked 1 time unit after that.
module tb_bus_arbiter;

    localparam logic [63:0] I_ADR = 64'h1004;
    localparam logic [63:0] D_ADR = 64'h2008;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bus_arbiter_if #(.AW(64)) bus ();

    bus_arbiter #(.AW(64), .TIMEOUT(255)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus.master)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_cyc_i = 1'b0; bus.i_stb_i = 1'b0; bus.i_adr_i = I_ADR;
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0; bus.d_we_i = 1'b0;
        bus.d_sel_i = 8'h00; bus.d_adr_i = D_ADR; bus.d_dat_i = 64'd0;
        bus.m_ack_i = 1'b0; bus.m_dat_i = 64'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bit exp_d;
        int err_at;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Reset state, with an ack asserted that must be ignored
        bus.m_ack_i = 1'b1;
        settle();
        chk("rst_state", bus.dbg_state, 2'd0);
        chk("rst_last_d", bus.dbg_last_d, 1'b0);
        chk("rst_m_cyc", bus.m_cyc_o, 1'b0);
        chk("rst_i_ack", bus.i_ack_o, 1'b0);
        chk("rst_d_ack", bus.d_ack_o, 1'b0);
        rst_n = 1'b1;
        bus.m_ack_i = 1'b0;
        tick();

        // Test 1: D transfer, then reset asserted mid-transfer
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_we_i = 1'b1;
        bus.d_sel_i = 8'hFF; bus.d_dat_i = 64'h1122334455667788;
        settle();
        chk("t1_req_m_cyc", bus.m_cyc_o, 1'b0);
        tick();
        chk("t1_gnt_state", bus.dbg_state, 2'd2);
        chk("t1_m_cyc", bus.m_cyc_o, 1'b1);
        chk("t1_m_we", bus.m_we_o, 1'b1);
        chk("t1_m_sel", bus.m_sel_o, 8'hFF);
        chk("t1_m_adr", bus.m_adr_o, D_ADR);
        chk("t1_m_dat", bus.m_dat_o, 64'h1122334455667788);
        bus.m_ack_i = 1'b1; bus.m_dat_i = 64'hDEADBEEF01234567;
        settle();
        chk("t1_d_ack", bus.d_ack_o, 1'b1);
        chk("t1_d_dat", bus.d_dat_o, 64'hDEADBEEF01234567);
        chk("t1_i_ack", bus.i_ack_o, 1'b0);
        rst_n = 1'b0;
        settle();
        chk("t1_rst_m_cyc", bus.m_cyc_o, 1'b0);
        chk("t1_rst_m_stb", bus.m_stb_o, 1'b0);
        chk("t1_rst_m_dat", bus.m_dat_o, 64'd0);
        chk("t1_rst_d_ack", bus.d_ack_o, 1'b0);
        chk("t1_rst_d_dat", bus.d_dat_o, 64'd0);
        clear_inputs();
        rst_n = 1'b1;
        tick();
        chk("t1_idle_state", bus.dbg_state, 2'd0);
        chk("t1_idle_m_cyc", bus.m_cyc_o, 1'b0);

        // Test 2: I alone, upper then lower half
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1; bus.i_adr_i = 64'h1004;
        tick();
        chk("t2_state", bus.dbg_state, 2'd1);
        chk("t2_m_sel_hi", bus.m_sel_o, 8'hF0);
        chk("t2_m_we", bus.m_we_o, 1'b0);
        chk("t2_m_dat", bus.m_dat_o, 64'd0);
        chk("t2_m_adr", bus.m_adr_o, 64'h1004);
        chk("t2_i_ack_wait", bus.i_ack_o, 1'b0);
        bus.m_ack_i = 1'b1; bus.m_dat_i = 64'hAAAAAAAA_BBBBBBBB;
        settle();
        chk("t2_i_ack", bus.i_ack_o, 1'b1);
        chk("t2_i_dat_hi", bus.i_dat_o, 32'hAAAAAAAA);
        chk("t2_d_ack", bus.d_ack_o, 1'b0);
        chk("t2_d_dat", bus.d_dat_o, 64'd0);
        tick();
        bus.i_adr_i = 64'h1000;
        settle();
        chk("t2_m_sel_lo", bus.m_sel_o, 8'h0F);
        chk("t2_i_dat_lo", bus.i_dat_o, 32'hBBBBBBBB);
        tick();
        clear_inputs();
        tick();
        chk("t2_rel_state", bus.dbg_state, 2'd0);
        chk("t2_rel_last_d", bus.dbg_last_d, 1'b0);

        // Test 3: simultaneous request after reset, D first, one dead cycle
        do_reset();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_sel_i = 8'h3C;
        tick();
        chk("t3_first_d", bus.dbg_state, 2'd2);
        chk("t3_m_sel", bus.m_sel_o, 8'h3C);
        bus.m_ack_i = 1'b1; bus.m_dat_i = 64'h55;
        settle();
        chk("t3_d_ack", bus.d_ack_o, 1'b1);
        chk("t3_i_ack_blocked", bus.i_ack_o, 1'b0);
        chk("t3_i_dat_blocked", bus.i_dat_o, 32'd0);
        tick();
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0; bus.m_ack_i = 1'b0;
        settle();
        chk("t3_dead_m_cyc", bus.m_cyc_o, 1'b0);
        tick();
        chk("t3_then_i", bus.dbg_state, 2'd1);
        chk("t3_m_cyc_i", bus.m_cyc_o, 1'b1);
        chk("t3_last_d", bus.dbg_last_d, 1'b1);

        // Test 4: both hold requests, one ack per grant -> D,I,D,I
        do_reset();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            exp_d = (r % 2 == 0);
            bus.m_ack_i = 1'b1;
            settle();
            chk("t4_owner_adr", bus.m_adr_o, exp_d ? D_ADR : I_ADR);
            chk("t4_d_ack", bus.d_ack_o, exp_d);
            chk("t4_i_ack", bus.i_ack_o, !exp_d);
            tick();
            bus.m_ack_i = 1'b0;
            if (exp_d) begin
                bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
            end else begin
                bus.i_cyc_i = 1'b0; bus.i_stb_i = 1'b0;
            end
            settle();
            chk("t4_dead_m_cyc", bus.m_cyc_o, 1'b0);
            tick();
            if (exp_d) begin
                bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1;
            end else begin
                bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
            end
        end

        // Test 5: 3-beat D burst while I waits; ack with stb=0 ignored
        do_reset();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1; bus.d_we_i = 1'b1; bus.d_sel_i = 8'hF0;
        tick();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bus.m_ack_i = 1'b1; bus.m_dat_i = 64'h100 + 64'(s);
            settle();
            chk("t5_d_ack", bus.d_ack_o, 1'b1);
            chk("t5_d_dat", bus.d_dat_o, 64'h100 + 64'(s));
            chk("t5_i_ack", bus.i_ack_o, 1'b0);
            tick();
        end
        bus.d_stb_i = 1'b0;
        settle();
        chk("t5_nostb_ack", bus.d_ack_o, 1'b0);
        chk("t5_hold_m_cyc", bus.m_cyc_o, 1'b1);
        chk("t5_m_stb", bus.m_stb_o, 1'b0);
        tick();
        bus.d_cyc_i = 1'b0; bus.m_ack_i = 1'b0;
        settle();
        chk("t5_dead_m_cyc", bus.m_cyc_o, 1'b0);
        chk("t5_i_ack_dead", bus.i_ack_o, 1'b0);
        tick();
        chk("t5_i_granted", bus.dbg_state, 2'd1);
        chk("t5_i_adr", bus.m_adr_o, I_ADR);

        // Test 6: D stalls with m_ack_i=0 while I waits
        do_reset();
        bus.d_cyc_i = 1'b1; bus.d_stb_i = 1'b1;
        tick();
        bus.i_cyc_i = 1'b1; bus.i_stb_i = 1'b1;
        settle();
        err_at = 0;
        for (int k = 1; k <= 300; k++) begin
            if (bus.d_err_o === 1'b1 && err_at == 0) begin
                err_at = k;
                break;
            end
            tick();
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        chk("t6_err_cycle", 64'(err_at), 64'd255);
        tick();
        bus.d_cyc_i = 1'b0; bus.d_stb_i = 1'b0;
        settle();
        chk("t6_revoked", bus.dbg_state, 2'd0);
        chk("t6_last_d", bus.dbg_last_d, 1'b1);
        tick();
        chk("t6_i_granted", bus.dbg_state, 2'd1);
        chk("t6_i_adr", bus.m_adr_o, I_ADR);
`else
        chk("t6_no_err", 64'(err_at), 64'd0);
        chk("t6_still_d", bus.dbg_state, 2'd2);
        chk("t6_i_err", bus.i_err_o, 1'b0);
        chk("t6_i_ack", bus.i_ack_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
